// File: rtl/conv_pkg.sv
// Shared types and constants for the 3x3 convolution stage and its Normalization consumer.
package conv_pkg;

   localparam int unsigned PIX_W = 8;
   localparam int unsigned SUM_W = 22;

   typedef logic [PIX_W-1:0]        pix_t;
   typedef logic signed [SUM_W-1:0] sum_t;

   // Row-major, top-left first.
   localparam logic signed [3:0] KERNEL [3][3] = '{
      '{ 4'sd0, -4'sd1,  4'sd0},
      '{ 4'sd1,  4'sd4,  4'sd1},
      '{ 4'sd0, -4'sd1,  4'sd0}
   };

   localparam int SUM_MIN = -510;
   localparam int SUM_MAX = 1530;

   // One kernel tap; 12 bits holds a full row of taps for this kernel.
   function automatic logic signed [11:0] tap_mul(input logic signed [3:0] k, input pix_t p);
      logic signed [11:0] ks;
      logic signed [11:0] ps;
      ks = 12'(k);
      ps = $signed({4'b0000, p});
      return ks * ps;
   endfunction

endpackage

// File: rtl/line_buffer.sv
// One image line of pixels. The old value at addr_i is visible combinationally and is
// replaced by wdata_i on the same edge, so cascaded instances shift lines in lockstep.
module line_buffer
   import conv_pkg::*;
#(
   parameter int unsigned Depth = 640,
   parameter int unsigned AddrW = $clog2(Depth)
) (
   input  logic             clk,
   input  logic             en_i,
   input  logic [AddrW-1:0] addr_i,
   input  logic [PIX_W-1:0] wdata_i,
   output logic [PIX_W-1:0] rdata_o
);

   pix_t mem_q [Depth];

   assign rdata_o = mem_q[addr_i];

   always_ff @(posedge clk) begin
      if (en_i) begin
         mem_q[addr_i] <= wdata_i;
      end
   end

endmodule

// File: rtl/conv3x3_stream.sv
// Streaming 3x3 convolution over raster pixels; stalls in lockstep with Normalization.
// Pipeline: window load (E0), row partial sums (E1), total and valid (E2).
module conv3x3_stream
   import conv_pkg::*;
#(
   parameter int unsigned IMG_W = 640,
   parameter int unsigned IMG_H = 480,
   parameter int unsigned SUM_W = conv_pkg::SUM_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic             sof,
   input  logic [PIX_W-1:0] pix_in,
   input  logic             pix_valid,
   output logic [SUM_W-1:0] sum_out,
   output logic             sum_valid,
   output logic             frame_done
);

   localparam int unsigned ColW = $clog2(IMG_W);
   localparam int unsigned RowW = $clog2(IMG_H);

   logic            accept;
   logic [ColW-1:0] col_q, col_eff, col_d;
   logic [RowW-1:0] row_q, row_eff, row_d;
   logic            at_eol, at_last, win_ok;
   pix_t            lb0_rd, lb1_rd;

   pix_t            win_q [3][3];
   logic            tag0_q, last0_q;

   logic signed [11:0] part_d [3];
   logic signed [11:0] part_q [3];
   logic               tag1_q, last1_q;
   logic signed [13:0] total;

   assign accept = pix_valid & ~stall;

   // sof relocates the current pixel to (0,0) before anything else looks at its position.
   always_comb begin
      col_eff = sof ? '0 : col_q;
      row_eff = sof ? '0 : row_q;
      at_eol  = (col_eff == ColW'(IMG_W - 1));
      at_last = at_eol && (row_eff == RowW'(IMG_H - 1));
      win_ok  = (row_eff >= RowW'(2)) && (col_eff >= ColW'(2));
      col_d   = col_eff + 1'b1;
      row_d   = row_eff;
      if (at_eol) begin
         col_d = '0;
         row_d = at_last ? '0 : row_eff + 1'b1;
      end
   end

   line_buffer #(
      .Depth (IMG_W),
      .AddrW (ColW)
   ) u_lb0 (
      .clk     (clk),
      .en_i    (accept),
      .addr_i  (col_eff),
      .wdata_i (pix_in),
      .rdata_o (lb0_rd)
   );

   line_buffer #(
      .Depth (IMG_W),
      .AddrW (ColW)
   ) u_lb1 (
      .clk     (clk),
      .en_i    (accept),
      .addr_i  (col_eff),
      .wdata_i (lb0_rd),
      .rdata_o (lb1_rd)
   );

   // E0: counters, window shift and tag.
   always_ff @(posedge clk) begin
      if (reset) begin
         col_q   <= '0;
         row_q   <= '0;
         tag0_q  <= 1'b0;
         last0_q <= 1'b0;
         for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
               win_q[r][c] <= '0;
            end
         end
      end else if (!stall) begin
         tag0_q  <= accept & win_ok;
         last0_q <= accept & at_last;
         if (accept) begin
            col_q <= col_d;
            row_q <= row_d;
            for (int r = 0; r < 3; r++) begin
               win_q[r][0] <= win_q[r][1];
               win_q[r][1] <= win_q[r][2];
            end
            win_q[0][2] <= lb1_rd;
            win_q[1][2] <= lb0_rd;
            win_q[2][2] <= pix_in;
         end
      end
   end

   always_comb begin
      for (int r = 0; r < 3; r++) begin
         part_d[r] = '0;
         for (int c = 0; c < 3; c++) begin
            part_d[r] = part_d[r] + tap_mul(KERNEL[r][c], win_q[r][c]);
         end
      end
   end

   assign total = 14'(part_q[0]) + 14'(part_q[1]) + 14'(part_q[2]);

   // E1 partial sums, E2 total; sum_out only moves on a valid window.
   always_ff @(posedge clk) begin
      if (reset) begin
         tag1_q     <= 1'b0;
         last1_q    <= 1'b0;
         sum_out    <= '0;
         sum_valid  <= 1'b0;
         frame_done <= 1'b0;
         for (int r = 0; r < 3; r++) begin
            part_q[r] <= '0;
         end
      end else if (!stall) begin
         tag1_q     <= tag0_q;
         last1_q    <= last0_q;
         for (int r = 0; r < 3; r++) begin
            part_q[r] <= part_d[r];
         end
         sum_valid  <= tag1_q;
         frame_done <= tag1_q & last1_q;
         if (tag1_q) begin
            sum_out <= SUM_W'(total);
         end
      end
   end

endmodule

// File: tb/tb_conv3x3_stream.sv
// Directed bench for conv3x3_stream on a 4x4 image with hand-computed window sums.
module tb_conv3x3_stream;
   import conv_pkg::*;

   logic        clk = 1'b0;
   logic        reset, stall, sof, pix_valid;
   logic [7:0]  pix_in;
   logic [21:0] sum_out;
   logic        sum_valid, frame_done;

   int   checks = 0;
   int   errors = 0;
   int   n_out  = 0;
   sum_t last_sum = '0;
   sum_t exp_sum [$];
   bit   exp_fd  [$];

   conv3x3_stream #(
      .IMG_W (4),
      .IMG_H (4),
      .SUM_W (22)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .stall      (stall),
      .sof        (sof),
      .pix_in     (pix_in),
      .pix_valid  (pix_valid),
      .sum_out    (sum_out),
      .sum_valid  (sum_valid),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic signed [31:0] obs,
                      input logic signed [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic observe();
      sum_t e;
      bit   f;
      if (sum_valid) begin
         n_out++;
         chk("out_expected", 32'(exp_sum.size() > 0), 1);
         if (exp_sum.size() > 0) begin
            e = exp_sum.pop_front();
            f = exp_fd.pop_front();
            chk("sum_out", $signed(sum_out), e);
            chk("frame_done", frame_done, f);
            last_sum = e;
         end
         chk("sum_range", 32'($signed(sum_out) >= SUM_MIN && $signed(sum_out) <= SUM_MAX), 1);
      end else begin
         chk("frame_done_idle", frame_done, 0);
         chk("sum_out_hold", $signed(sum_out), last_sum);
      end
   endtask

   task automatic drive(input logic v, input logic [7:0] p, input logic s, input logic st);
      pix_valid = v;
      pix_in    = p;
      sof       = s;
      stall     = st;
      @(posedge clk);
      #1;
      if (!st) observe();
   endtask

   task automatic push4(input sum_t a, input sum_t b, input sum_t c, input sum_t d);
      exp_sum.push_back(a); exp_fd.push_back(1'b0);
      exp_sum.push_back(b); exp_fd.push_back(1'b0);
      exp_sum.push_back(c); exp_fd.push_back(1'b0);
      exp_sum.push_back(d); exp_fd.push_back(1'b1);
   endtask

   // rows[8r+:8] is the value of every pixel in row r; stall_at < 0 means no stall.
   task automatic send_frame(input logic [31:0] rows, input logic first_sof, input int stall_at);
      int idx;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            idx = r * 4 + c;
            if (idx == stall_at) begin
               for (int k = 0; k < 5; k++) begin
                  drive(1'b1, rows[8*r +: 8], 1'b0, 1'b1);
                  chk("stall_valid", sum_valid, 1);
                  chk("stall_sum", $signed(sum_out), 1530);
                  chk("stall_fd", frame_done, 0);
               end
            end
            drive(1'b1, rows[8*r +: 8], first_sof && idx == 0, 1'b0);
         end
      end
      repeat (3) drive(1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   task automatic end_test(input string tag);
      chk(tag, n_out, 4);
      n_out = 0;
   endtask

   task automatic apply_reset();
      reset     = 1'b1;
      pix_valid = 1'b0;
      sof       = 1'b0;
      stall     = 1'b0;
      pix_in    = '0;
      @(posedge clk);
      #1;
      reset    = 1'b0;
      last_sum = '0;
      chk("rst_valid", sum_valid, 0);
      chk("rst_sum", $signed(sum_out), 0);
      chk("rst_fd", frame_done, 0);
   endtask

   initial begin
      reset = 1'b1; stall = 1'b0; sof = 1'b0; pix_valid = 1'b0; pix_in = '0;
      @(posedge clk);
      apply_reset();

      // All-zero frame.
      push4(0, 0, 0, 0);
      send_frame(32'h0000_0000, 1'b1, -1);
      end_test("count_zero");

      // All-255 frame: -255 + 6*255 - 255.
      push4(1020, 1020, 1020, 1020);
      send_frame(32'hFFFF_FFFF, 1'b1, -1);
      end_test("count_ones");

      // Row 1 bright: centre row then top row of the window.
      push4(1530, 1530, -255, -255);
      send_frame(32'h0000_FF00, 1'b1, -1);
      end_test("count_row1");

      // Rows 0 and 2 bright.
      push4(-510, -510, 1530, 1530);
      send_frame(32'h00FF_00FF, 1'b1, -1);
      end_test("count_row02");

      // Same as row-1 frame with a 5-cycle stall before pixel (3,1).
      push4(1530, 1530, -255, -255);
      send_frame(32'h0000_FF00, 1'b1, 13);
      end_test("count_stall");

      // Reset after 7 pixels, then a frame without sof.
      for (int i = 0; i < 7; i++) drive(1'b1, 8'hFF, i == 0, 1'b0);
      apply_reset();
      push4(1020, 1020, 1020, 1020);
      send_frame(32'hFFFF_FFFF, 1'b0, -1);
      end_test("count_after_reset");

      // 10 stray pixels, then sof restarts the frame.
      for (int i = 0; i < 10; i++) drive(1'b1, 8'd77, 1'b0, 1'b0);
      push4(1020, 1020, 1020, 1020);
      send_frame(32'hFFFF_FFFF, 1'b1, -1);
      end_test("count_sof_resync");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
